// File: rtl/i2c_slave.sv
// I2C target (responder) with 7-bit addressing and byte FIFO interfaces.
//
// SCL/SDA are oversampled on clk (clk must be at least 8x the SCL rate) and
// SCL is never stretched. Received bytes are pushed into an external RX FIFO.
// Transmitted bytes are popped from an external TX FIFO.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   scl_i      bus SCL (asynchronous)
//   sda_i      bus SDA (asynchronous)
//   sda_o      open-drain SDA drive: 0 = pull low, 1 = release
//   rx_data    received byte, valid while rxff_wr is high
//   rxff_wr    1-cycle push strobe for the RX FIFO
//   rxff_full  RX FIFO full
//   tx_data    head of the TX FIFO
//   txff_rd    1-cycle pop strobe; tx_data is captured in the same cycle
//   txff_empty TX FIFO empty
//   busy       high from address match until STOP or START
//   addr_nack  1-cycle pulse when an address phase does not match
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rxff_wr,
    input  logic       rxff_full,
    input  logic [7:0] tx_data,
    output logic       txff_rd,
    input  logic       txff_empty,
    output logic       busy,
    output logic       addr_nack
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRxData,
        StRxAck,
        StTxData,
        StTxAck,
        StWaitStop
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge / bus-condition detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA change coincident with an
    // SCL edge is not mistaken for a bus condition.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;   // RX: bits sampled, TX: bits driven
    logic [7:0]  shift_q, shift_d;
    logic        sda_q, sda_d;
    logic        busy_q, busy_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rxff_wr_q, rxff_wr_d;
    logic        addr_nack_q, addr_nack_d;
    logic        rw_q, rw_d;
    logic        rx_nack_q, rx_nack_d;   // last received byte was NACKed
    logic        mack_q, mack_d;         // SDA level sampled in the master ACK slot
    logic        load_tx;
    logic [7:0]  tx_byte;

    // An empty TX FIFO reads as all ones, which leaves SDA released.
    assign tx_byte = txff_empty ? 8'hFF : tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rxff_wr_q   <= 1'b0;
            addr_nack_q <= 1'b0;
            rw_q        <= 1'b0;
            rx_nack_q   <= 1'b0;
            mack_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rxff_wr_q   <= rxff_wr_d;
            addr_nack_q <= addr_nack_d;
            rw_q        <= rw_d;
            rx_nack_q   <= rx_nack_d;
            mack_q      <= mack_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rxff_wr_d   = 1'b0;
        addr_nack_d = 1'b0;
        rw_d        = rw_q;
        rx_nack_d   = rx_nack_q;
        mack_d      = mack_q;
        load_tx     = 1'b0;

        if (stop_det) begin
            state_d = StIdle;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_d     = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: sda_d = 1'b1;

                // The SCL fall right after START arrives with bit_cnt 0 and is ignored.
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_d   = 1'b0;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = StAddrAck;
                        end else begin
                            addr_nack_d = 1'b1;
                            state_d     = StWaitStop;
                        end
                    end
                end

                StAddrAck: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_d     = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = StRxData;
                        end
                    end
                end

                StRxData: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (!rxff_full) begin
                            rx_data_d = shift_q;
                            rxff_wr_d = 1'b1;
                            sda_d     = 1'b0;
                            rx_nack_d = 1'b0;
                        end else begin
                            sda_d     = 1'b1;
                            rx_nack_d = 1'b1;
                        end
                        state_d = StRxAck;
                    end
                end

                StRxAck: begin
                    if (scl_fall) begin
                        sda_d = 1'b1;
                        if (rx_nack_q) begin
                            state_d = StWaitStop;
                        end else begin
                            bit_cnt_d = 4'd0;
                            state_d   = StRxData;
                        end
                    end
                end

                // bit7 was driven at load time; each fall drives the next bit
                // until all eight have been clocked out.
                StTxData: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_d   = 1'b1;
                            state_d = StTxAck;
                        end else begin
                            sda_d     = shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                StTxAck: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = StWaitStop;
                        end
                    end
                end

                StWaitStop: sda_d = 1'b1;

                default: state_d = StIdle;
            endcase

            if (load_tx) begin
                shift_d   = tx_byte;
                sda_d     = tx_byte[7];
                bit_cnt_d = 4'd1;
                state_d   = StTxData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        sda_o     = sda_q;
        rx_data   = rx_data_q;
        rxff_wr   = rxff_wr_q;
        busy      = busy_q;
        addr_nack = addr_nack_q;
        // Pop in the same cycle the shift register captures tx_data.
        txff_rd   = load_tx & ~txff_empty;
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: an I2C master bus model drives SCL/SDA
// (open-drain with the DUT), a TX FIFO model feeds tx_data, and received
// bytes are matched against a scoreboard queue of expected pushes.
module tb_i2c_slave;

    localparam int CLK_HALF = 5;
    localparam int Q        = 100;   // quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rxff_wr;
    logic       rxff_full;
    logic [7:0] tx_data;
    logic       txff_rd;
    logic       txff_empty;
    logic       busy;
    logic       addr_nack;
    wire        sda_line = sda_m & sda_o;

    always #(CLK_HALF) clk = ~clk;

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .rx_data    (rx_data),
        .rxff_wr    (rxff_wr),
        .rxff_full  (rxff_full),
        .tx_data    (tx_data),
        .txff_rd    (txff_rd),
        .txff_empty (txff_empty),
        .busy       (busy),
        .addr_nack  (addr_nack)
    );

    // TX FIFO model: entries written by the stimulus, popped on txff_rd.
    logic [7:0] tx_mem [16];
    int         tx_cnt  = 0;
    int         tx_pops = 0;
    assign tx_data    = tx_mem[tx_pops[3:0]];
    assign txff_empty = (tx_pops >= tx_cnt);

    always @(posedge clk) begin
        if (txff_rd) tx_pops <= tx_pops + 1;
    end

    // Output monitor: logs pushes and counts pulses and stretched strobes.
    logic [7:0] rx_log [64];
    int         rx_n     = 0;
    int         nack_n   = 0;
    int         low_n    = 0;
    int         rx_wide  = 0;
    int         tx_wide  = 0;
    logic       rx_prev  = 1'b0;
    logic       tx_prev  = 1'b0;

    always @(negedge clk) begin
        if (rxff_wr) begin
            rx_log[rx_n[5:0]] <= rx_data;
            rx_n <= rx_n + 1;
        end
        if (addr_nack) nack_n <= nack_n + 1;
        if (!sda_o) low_n <= low_n + 1;
        if (rxff_wr && rx_prev) rx_wide <= rx_wide + 1;
        if (txff_rd && tx_prev) tx_wide <= tx_wide + 1;
        rx_prev <= rxff_wr;
        tx_prev <= txff_rd;
    end

    int         checks = 0;
    int         errors = 0;
    int         rx_rp  = 0;
    logic [7:0] rx_exp [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Compare every logged push against the scoreboard, in order.
    task automatic drain();
        while (rx_rp < rx_n) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got 0x%0h want no push", rx_log[rx_rp[5:0]]);
            end else begin
                check("rx_data", {24'd0, rx_log[rx_rp[5:0]]}, {24'd0, rx_exp.pop_front()});
            end
            rx_rp++;
        end
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_mem[tx_cnt[3:0]] = b;
        tx_cnt++;
    endtask

    // Bus primitives; every task starts and ends with SCL low, except
    // bus_stop which leaves the bus idle.
    task automatic bus_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    #(Q);
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_line; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic bv;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(bv);
        ack = ~bv;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            b[i] = bv;
        end
        write_bit(~ack);
    endtask

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       full;
        logic       aack;
        logic       dack;
    } wr_vec_t;

    localparam int NV = 5;
    wr_vec_t vecs [NV];

    initial begin
        wr_vec_t    v;
        logic       ack;
        logic       bv;
        logic [7:0] rd;
        int         rx0, tx0, nk0, lw0;

        vecs[0] = '{addr: 8'hA0, data: 8'hA5, full: 1'b0, aack: 1'b1, dack: 1'b1};
        vecs[1] = '{addr: 8'hA3, data: 8'h3C, full: 1'b0, aack: 1'b0, dack: 1'b0};
        vecs[2] = '{addr: 8'hA0, data: 8'h00, full: 1'b1, aack: 1'b1, dack: 1'b0};
        vecs[3] = '{addr: 8'hA0, data: 8'hFF, full: 1'b0, aack: 1'b1, dack: 1'b1};
        vecs[4] = '{addr: 8'h20, data: 8'h81, full: 1'b0, aack: 1'b0, dack: 1'b0};

        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rxff_full = 1'b0;
        #3 rst = 1'b0;
        #20;
        check("rst_sda_o", {31'd0, sda_o}, 32'd1);
        check("rst_rxff_wr", {31'd0, rxff_wr}, 32'd0);
        check("rst_txff_rd", {31'd0, txff_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr_nack", {31'd0, addr_nack}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Table of single-byte writes.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            rx0 = rx_n;
            nk0 = nack_n;
            if (v.dack) rx_exp.push_back(v.data);
            bus_start();
            write_byte(v.addr, ack);
            check("vec_addr_ack", {31'd0, ack}, {31'd0, v.aack});
            check("vec_busy", {31'd0, busy}, {31'd0, v.aack});
            rxff_full = v.full;
            write_byte(v.data, ack);
            rxff_full = 1'b0;
            check("vec_data_ack", {31'd0, ack}, {31'd0, v.dack});
            bus_stop();
            check("vec_busy_after_stop", {31'd0, busy}, 32'd0);
            check("vec_push_count", rx_n - rx0, {31'd0, v.dack});
            check("vec_nack_count", nack_n - nk0, {31'd0, ~v.aack});
            drain();
        end

        // Two-byte write A5 3C.
        rx0 = rx_n;
        rx_exp.push_back(8'hA5);
        rx_exp.push_back(8'h3C);
        bus_start();
        write_byte(8'hA0, ack);
        check("w2_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hA5, ack);
        check("w2_d0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h3C, ack);
        check("w2_d1_ack", {31'd0, ack}, 32'd1);
        check("w2_busy", {31'd0, busy}, 32'd1);
        bus_stop();
        check("w2_busy_after_stop", {31'd0, busy}, 32'd0);
        check("w2_push_count", rx_n - rx0, 32'd2);
        drain();

        // Address 0x51 write: SDA never pulled low.
        rx0 = rx_n;
        nk0 = nack_n;
        lw0 = low_n;
        bus_start();
        write_byte(8'hA2, ack);
        check("nm_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack);
        check("nm_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        check("nm_nack_count", nack_n - nk0, 32'd1);
        check("nm_sda_low_cycles", low_n - lw0, 32'd0);
        check("nm_push_count", rx_n - rx0, 32'd0);
        check("nm_busy", {31'd0, busy}, 32'd0);

        // Read 11 22, master ACK then NACK.
        tx_push(8'h11);
        tx_push(8'h22);
        tx0 = tx_pops;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(rd, 1'b1);
        check("rd_byte0", {24'd0, rd}, 32'h11);
        read_byte(rd, 1'b0);
        check("rd_byte1", {24'd0, rd}, 32'h22);
        check("rd_sda_released", {31'd0, sda_o}, 32'd1);
        bus_stop();
        check("rd_pop_count", tx_pops - tx0, 32'd2);
        check("rd_busy", {31'd0, busy}, 32'd0);

        // RX FIFO full on the second byte.
        rx0 = rx_n;
        rx_exp.push_back(8'h77);
        bus_start();
        write_byte(8'hA0, ack);
        check("full_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h77, ack);
        check("full_d0_ack", {31'd0, ack}, 32'd1);
        rxff_full = 1'b1;
        write_byte(8'h88, ack);
        rxff_full = 1'b0;
        check("full_d1_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h99, ack);
        check("full_ignored", {31'd0, ack}, 32'd0);
        bus_stop();
        check("full_push_count", rx_n - rx0, 32'd1);
        drain();

        // Write one byte, repeated START, read with TX FIFO empty.
        rx0 = rx_n;
        tx0 = tx_pops;
        rx_exp.push_back(8'h42);
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_waddr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h42, ack);
        check("rs_data_ack", {31'd0, ack}, 32'd1);
        bus_start();
        write_byte(8'hA1, ack);
        check("rs_raddr_ack", {31'd0, ack}, 32'd1);
        read_byte(rd, 1'b0);
        check("rs_empty_byte", {24'd0, rd}, 32'hFF);
        bus_stop();
        check("rs_pop_count", tx_pops - tx0, 32'd0);
        check("rs_push_count", rx_n - rx0, 32'd1);
        drain();

        // STOP at bit 4 of a data byte, then a clean transfer.
        rx0 = rx_n;
        bus_start();
        write_byte(8'hA0, ack);
        check("sp_addr_ack", {31'd0, ack}, 32'd1);
        write_bit(1'b1);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b0);
        bus_stop();
        check("sp_busy", {31'd0, busy}, 32'd0);
        check("sp_sda_o", {31'd0, sda_o}, 32'd1);
        rx_exp.push_back(8'h5E);
        bus_start();
        write_byte(8'hA0, ack);
        check("sp_next_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h5E, ack);
        check("sp_next_data_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        check("sp_push_count", rx_n - rx0, 32'd1);
        drain();

        // Reset mid-byte while the target is driving a 0 data bit.
        tx_push(8'h00);
        bus_start();
        write_byte(8'hA1, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 3; i++) read_bit(bv);
        check("rr_driving_low", {31'd0, sda_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("rr_sda_released", {31'd0, sda_o}, 32'd1);
        check("rr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        bus_stop();
        rx0 = rx_n;
        rx_exp.push_back(8'h6D);
        bus_start();
        write_byte(8'hA0, ack);
        check("rr_next_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h6D, ack);
        check("rr_next_data_ack", {31'd0, ack}, 32'd1);
        bus_stop();
        check("rr_push_count", rx_n - rx0, 32'd1);
        drain();

        repeat (5) @(negedge clk);
        check("rx_exp_left", rx_exp.size(), 32'd0);
        check("rxff_wr_width", rx_wide, 32'd0);
        check("txff_rd_width", tx_wide, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
